// File: rtl/wb_dbg_bridge.sv
// Wishbone debug initiator: framed command bytes in, single classic cycles out, result bytes back.
// Build option DBG_BRIDGE_AUTOINC_EN adds address post-increment and the 'N'/'n' commands.
module wb_dbg_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack
);

  localparam logic [7:0] CmdWrite   = 8'h57;
  localparam logic [7:0] CmdRead    = 8'h52;
  localparam logic [7:0] RspOk      = 8'h4B;
  localparam logic [7:0] RspUnknown = 8'h3F;
  localparam logic [7:0] RspTimeout = 8'h54;
`ifdef DBG_BRIDGE_AUTOINC_EN
  localparam logic [7:0] CmdNextRead  = 8'h4E;
  localparam logic [7:0] CmdNextWrite = 8'h6E;
`endif

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                cyc_q, cyc_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic                rx_fire, tx_fire, timeout_hit;

  // Gated by reset so the handshake is closed while reset is held.
  assign o_rx_ready  = !i_reset && (state_q inside {StIdle, StAddr, StData});
  assign rx_fire     = i_rx_valid && o_rx_ready;
  assign tx_fire     = tx_valid_q && i_tx_ready;
  assign timeout_hit = (TIMEOUT != 0) && (32'(to_q) == TIMEOUT - 32'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cyc_d      = cyc_q;
    to_d       = to_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          cnt_d = '0;
          case (i_rx_data)
            CmdWrite, CmdRead: begin
              we_d    = (i_rx_data == CmdWrite);
              state_d = StAddr;
            end
`ifdef DBG_BRIDGE_AUTOINC_EN
            CmdNextRead: begin
              we_d    = 1'b0;
              cyc_d   = 1'b1;
              to_d    = '0;
              state_d = StBus;
            end
            CmdNextWrite: begin
              we_d    = 1'b1;
              state_d = StData;
            end
`endif
            default: begin
              tx_data_d  = RspUnknown;
              tx_valid_d = 1'b1;
              state_d    = StResp;
            end
          endcase
        end
      end
      StAddr: begin
        if (rx_fire) begin
          adr_d = {adr_q[23:0], i_rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = StData;
            end else begin
              cyc_d   = 1'b1;
              to_d    = '0;
              state_d = StBus;
            end
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          dat_d = {dat_q[23:0], i_rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cyc_d   = 1'b1;
            to_d    = '0;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // Ack wins over a timeout firing in the same cycle.
        if (i_wb_ack) begin
          cyc_d      = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = StResp;
          if (we_q) begin
            tx_data_d = RspOk;
            cnt_d     = 2'd0;
          end else begin
            tx_data_d = i_wb_dat[31:24];
            shift_d   = i_wb_dat[23:0];
            cnt_d     = 2'd3;
          end
`ifdef DBG_BRIDGE_AUTOINC_EN
          adr_d = adr_q + 32'd4;
`endif
        end else if (timeout_hit) begin
          cyc_d      = 1'b0;
          tx_data_d  = RspTimeout;
          tx_valid_d = 1'b1;
          cnt_d      = 2'd0;
          state_d    = StResp;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      StResp: begin
        // cnt_q counts the bytes still to follow the one on the bus.
        if (tx_fire) begin
          if (cnt_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            tx_data_d = shift_q[23:16];
            shift_d   = {shift_q[15:0], 8'h00};
            cnt_d     = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cyc_q      <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cyc_q      <= cyc_d;
      to_q       <= to_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = 4'hF;
  assign o_wb_stb   = cyc_q;
  assign o_wb_cyc   = cyc_q;

endmodule
